// File: rtl/program_loader.sv
// program_loader: length-prefixed byte stream to 32-bit big-endian instruction memory writes, stalling the CPU while it loads.
module program_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error
);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR} state_t;
  localparam logic [15:0] DEPTH = 16'(MEMORY_DEPTH);
  state_t                r_state, w_next;
  logic [15:0]           r_count, r_k, w_len;
  logic [1:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  w_accept, w_start;
  assign ByteReady    = r_state inside {LEN_HI, LEN_LO, DATA};
  assign w_accept     = ByteValid && ByteReady;
  assign w_start      = Start && (r_state inside {IDLE, DONE, ERROR});
  assign w_len        = {r_count[15:8], ByteIn};
  assign WriteEnable  = r_state == WRITE;
  assign WriteAddress = DATA_WIDTH'({r_k, 2'b00});
  assign WriteData    = r_word;
  assign CpuHold      = r_state inside {LEN_HI, LEN_LO, DATA, WRITE};
  assign Done         = r_state == DONE;
  assign Error        = r_state == ERROR;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERROR: w_next = w_start ? LEN_HI : r_state;
      LEN_HI: w_next = w_accept ? LEN_LO : LEN_HI;
      LEN_LO: w_next = !w_accept ? LEN_LO : (w_len == 16'd0) ? DONE : (w_len > DEPTH) ? ERROR : DATA;
      DATA:   w_next = (w_accept && r_idx == 2'd3) ? WRITE : DATA;
      WRITE:  w_next = (r_k + 16'd1 == r_count) ? DONE : DATA;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_k     <= '0;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_count <= '0;
        r_k     <= '0;
        r_idx   <= '0;
        r_word  <= '0;
      end
      if (w_accept && r_state == LEN_HI) r_count[15:8] <= ByteIn;
      if (w_accept && r_state == LEN_LO) r_count[7:0] <= ByteIn;
      if (w_accept && r_state == DATA) begin
        r_word <= {r_word[DATA_WIDTH-9:0], ByteIn};
        r_idx  <= r_idx + 2'd1;
      end
      if (r_state == WRITE) r_k <= r_k + 16'd1;
    end
  end
endmodule

// File: doc/program_loader.md
# program_loader

Serial boot loader that writes a program image into the instruction memory before the processor runs. It accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian instruction words, and issues one write per word at consecutive byte addresses. It holds the CPU stalled while loading and reports completion or an oversize-image error.

## Interface
- MEMORY_DEPTH, 32, instruction words the target memory holds; maximum accepted image length.
- DATA_WIDTH, 32, instruction word and address width; fixed at 32.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- ByteIn  input  8  incoming stream byte.
- ByteValid  input  1  ByteIn holds a valid byte.
- ByteReady  output  1  loader can accept a byte this cycle.
- WriteEnable  output  1  one-cycle write strobe to instruction memory.
- WriteAddress  output  DATA_WIDTH  byte address of the word being written; always a multiple of 4.
- WriteData  output  DATA_WIDTH  assembled instruction word.
- CpuHold  output  1  high from Start until DONE or ERROR; holds the processor stalled.
- Done  output  1  level; image fully written.
- Error  output  1  level; header count exceeded MEMORY_DEPTH.

## Operation
- Stream format: 2-byte word count N, MSB first, then 4·N image bytes, each word MSB first (byte 0 → bits 31:24).
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE: ByteReady=0. Start → LEN_HI; clear word counter, byte index and address.
- LEN_HI / LEN_LO: ByteReady=1. Each accepted byte (ByteValid && ByteReady) loads count[15:8] then count[7:0]; leave the state on accept.
- After LEN_LO accept: N=0 → DONE; N>MEMORY_DEPTH → ERROR; otherwise → DATA.
- DATA: ByteReady=1; an accepted byte shifts into the word shift register (word = {word[23:0], ByteIn}) and increments the 2-bit byte index. On the 4th accept → WRITE.
- WRITE: ByteReady=0; WriteEnable=1 for exactly one cycle with WriteData = assembled word and WriteAddress = 4·k, where k is the word index (0-based). Then increment k; k==N → DONE, else → DATA.
- DONE: Done=1, CpuHold=0, ByteReady=0. ERROR: Error=1, CpuHold=0, ByteReady=0. Both are sticky until reset or Start.
- Start from DONE/ERROR clears Done/Error and restarts at LEN_HI. Start in any other state is ignored.
- ByteValid outside LEN_HI/LEN_LO/DATA is ignored; no bytes are consumed.
- Word counter is 16 bits; the address is {k, 2'b00} zero-extended to DATA_WIDTH.

## Timing
- Reset values: state IDLE, ByteReady 0, WriteEnable 0, WriteAddress 0, WriteData 0, CpuHold 0, Done 0, Error 0.
- CpuHold rises the cycle after Start is sampled and falls the cycle DONE or ERROR is entered.
- Write latency: WriteEnable is asserted in the cycle after the 4th byte of a word is accepted. WriteData and WriteAddress are stable in that cycle.
- Peak throughput: 4 bytes in 4 cycles plus 1 WRITE bubble per word, so 5 cycles per word.
- ByteValid may drop at any time; the loader waits indefinitely with partial state preserved. There is no timeout.
- Reset mid-load aborts immediately: the next cycle is IDLE with all outputs at reset values. A partial word is discarded and is never written.
- Done/Error assert the cycle after the final WRITE cycle or the LEN_LO accept, respectively.

## Test plan
- Reset, Start, stream 00 02 | 24 08 00 05 | 00 00 00 08 with ByteValid held high → writes (0x00000000, 0x24080005) then (0x00000004, 0x00000008); WriteEnable pulses exactly twice; Done=1; CpuHold low after the second write.
- Header 00 00 → Done=1 one cycle after the 2nd byte; no WriteEnable pulse.
- Header 00 21 with MEMORY_DEPTH=32 → Error=1, Done=0, no writes; ByteReady=0 afterwards; a new Start then a valid 1-word image → Done=1, Error=0.
- Image of 32 words (count 00 20) with random ByteValid gaps → 32 writes at addresses 0x00 through 0x7C with data matching the stream; ByteReady=0 during every WRITE cycle.
- Assert reset after 2 data bytes of word 1 → no write occurs; all outputs return to reset values in the next cycle; a fresh load then works normally.
- Start pulsed during DATA and while ByteValid is high in IDLE → both are ignored; state and counters are unchanged.
